// File: rtl/store_queue.sv
// -----------------------------------------------------------------------------
// store_queue
//
// Store path between the MEM stage and data memory. A store request
// (word / half / byte) is turned into a word address, byte enables and
// lane-shifted data, then buffered in a DEPTH-entry circular FIFO. The head
// entry drains to memory over a req/ack handshake. ld_hit flags a load whose
// word address matches any pending store so the hazard unit can stall it.
//
// Optional feature (compile-time macro): STORE_MERGE_EN
//   When defined, an accepted store that hits the word of the youngest (tail)
//   entry merges into it instead of pushing, provided at least two entries
//   are valid. The head is never merged into because it may be in flight.
//
// Store select codes (mirrors the MEM_STORE_* values of const.v):
//   3'd1 word, 3'd2 half, 3'd3 byte; anything else means no store.
//
// Parameters:
//   DEPTH   number of queue entries (power of two, >= 2)
//   ADDR_W  byte-address width
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   st_valid     store request this cycle
//   st_sel       store size code
//   st_addr      store byte address
//   st_data      raw register data
//   st_ready     queue can accept a push (count != DEPTH)
//   st_misalign  current store is misaligned (combinational)
//   mem_req      head entry valid
//   mem_addr     head word address, low two bits zero
//   mem_be       head byte enables
//   mem_wdata    head lane-aligned write data
//   mem_ack      memory accepts the head this cycle
//   ld_addr      load address from the MEM stage
//   ld_hit       some valid entry holds the load's word (combinational)
//   empty        count == 0
//   count        number of valid entries
// -----------------------------------------------------------------------------
module store_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [2:0]                 st_sel,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    output logic                       st_ready,
    output logic                       st_misalign,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [3:0]                 mem_be,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ack,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = ADDR_W - 2;

    localparam logic [2:0] MEM_STORE_WORD = 3'd1;
    localparam logic [2:0] MEM_STORE_HALF = 3'd2;
    localparam logic [2:0] MEM_STORE_BYTE = 3'd3;

    // Clears the byte offset when comparing a full address against a word.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{WW{1'b1}}, 2'b00};

    // Entry storage
    logic [WW-1:0]    r_word  [DEPTH];
    logic [3:0]       r_be    [DEPTH];
    logic [31:0]      r_data  [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    // Request encoding
    logic [1:0]    w_a;
    logic [WW-1:0] w_word;
    logic          w_sel_ok;
    logic          w_bad_align;
    logic [3:0]    w_be;
    logic [31:0]   w_data;
    logic          w_accept;
    logic          w_merge;
    logic          w_push;
    logic          w_pop;

    assign w_a    = st_addr[1:0];
    assign w_word = st_addr[ADDR_W-1:2];

    // NOTE: every signal driven here gets a default first so no path through
    // the case statement leaves it unassigned and infers a latch.
    always_comb begin
        w_sel_ok    = 1'b0;
        w_bad_align = 1'b0;
        w_be        = 4'b0000;
        w_data      = 32'h0;
        case (st_sel)
            MEM_STORE_WORD: begin
                w_sel_ok    = 1'b1;
                w_bad_align = (w_a != 2'b00);
                w_be        = 4'b1111;
                w_data      = st_data;
            end
            MEM_STORE_HALF: begin
                w_sel_ok    = 1'b1;
                w_bad_align = w_a[0];
                w_be        = w_a[1] ? 4'b1100 : 4'b0011;
                w_data      = st_data << {w_a[1], 4'b0000};
            end
            MEM_STORE_BYTE: begin
                w_sel_ok    = 1'b1;
                w_be        = 4'b0001 << w_a;
                w_data      = st_data << {w_a, 3'b000};
            end
            default: ;
        endcase
    end

    assign st_misalign = st_valid && w_bad_align;
    assign w_accept    = st_valid && w_sel_ok && !w_bad_align;

    // st_ready depends on registered state only, so a push into a full queue
    // is rejected even when the head is acked in the same cycle.
    assign st_ready = (r_count != CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;

`ifdef STORE_MERGE_EN
    logic [PW-1:0] w_tail_last;

    // Youngest entry; count >= 2 guarantees it is not the head.
    assign w_tail_last = r_tail - PW'(1);
    assign w_merge     = w_accept && (r_count >= CW'(2))
                         && (r_word[w_tail_last] == w_word);
`else
    assign w_merge = 1'b0;
`endif

    assign w_push = w_accept && st_ready && !w_merge;
    assign w_pop  = mem_req && mem_ack;

    // Pointers, occupancy and valid bits.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: payload storage has no reset; an entry is only observed while its
    // valid bit is set, and the outputs are forced to zero when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_word[r_tail] <= w_word;
            r_be[r_tail]   <= w_be;
            r_data[r_tail] <= w_data;
        end
`ifdef STORE_MERGE_EN
        else if (w_merge) begin
            r_be[w_tail_last] <= r_be[w_tail_last] | w_be;
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_data[w_tail_last][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
`endif
    end

    // Memory side: head registers, zeroed while the queue is empty.
    assign mem_req   = !empty;
    assign mem_addr  = mem_req ? {r_word[r_head], 2'b00} : '0;
    assign mem_be    = mem_req ? r_be[r_head]            : 4'b0000;
    assign mem_wdata = mem_req ? r_data[r_head]          : 32'h0;

    // Load hazard: any valid entry on the same word. An entry being popped
    // this cycle is still valid until the edge, so it still reports a hit.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && ((({r_word[i], 2'b00} ^ ld_addr) & WORD_MASK) == '0)) begin
                ld_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int CW     = $clog2(DEPTH+1);

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_WORD = 3'd1;
    localparam logic [2:0] SEL_HALF = 3'd2;
    localparam logic [2:0] SEL_BYTE = 3'd3;

    logic              clk = 1'b0;
    logic              reset;
    logic              st_valid;
    logic [2:0]        st_sel;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              st_ready;
    logic              st_misalign;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic              empty;
    logic [CW-1:0]     count;

    int n_cmp = 0;
    int n_err = 0;

    store_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_sel      (st_sel),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .st_misalign (st_misalign),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .empty       (empty),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks run 1 ns later still.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_sel   = sel;
        st_addr  = addr;
        st_data  = data;
    endtask

    task automatic idle();
        st_valid = 1'b0;
        st_sel   = SEL_NONE;
        st_addr  = '0;
        st_data  = '0;
    endtask

    task automatic push(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
        drive(sel, addr, data);
        tick();
        idle();
    endtask

    task automatic check_head(input string tag, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] data);
        check({tag, "_req"},   mem_req,   1'b1);
        check({tag, "_addr"},  mem_addr,  addr);
        check({tag, "_be"},    mem_be,    be);
        check({tag, "_wdata"}, mem_wdata, data);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_empty"}, empty,     1'b1);
        check({tag, "_count"}, count,     '0);
        check({tag, "_req"},   mem_req,   1'b0);
        check({tag, "_addr"},  mem_addr,  '0);
        check({tag, "_be"},    mem_be,    '0);
        check({tag, "_wdata"}, mem_wdata, '0);
    endtask

    initial begin
        reset   = 1'b1;
        mem_ack = 1'b0;
        ld_addr = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        settle();

        // Reset state
        check_idle_outputs("rst");
        check("rst_ready", st_ready, 1'b1);

        // Byte store after reset, ack held low
        drive(SEL_BYTE, 32'h13, 32'hA5);
        settle();
        check("sb_misalign", st_misalign, 1'b0);
        tick();
        idle();
        check_head("sb", 32'h10, 4'b1000, 32'hA500_0000);
        check("sb_count", count, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_idle_outputs("sb_drain");

        // Misaligned and invalid-select stores are rejected
        drive(SEL_HALF, 32'h21, 32'h1234);
        settle();
        check("sh21_misalign", st_misalign, 1'b1);
        tick();
        check("sh21_count", count, 0);
        drive(SEL_WORD, 32'h22, 32'h5678);
        settle();
        check("sw22_misalign", st_misalign, 1'b1);
        tick();
        check("sw22_count", count, 0);
        drive(SEL_NONE, 32'h21, 32'h9999);
        settle();
        check("nosel_misalign", st_misalign, 1'b0);
        tick();
        check("nosel_count", count, 0);

        // Aligned half store to the upper lanes
        drive(SEL_HALF, 32'h22, 32'h1234);
        settle();
        check("sh22_misalign", st_misalign, 1'b0);
        tick();
        idle();
        check_head("sh22", 32'h20, 4'b1100, 32'h1234_0000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sh22_drained", empty, 1'b1);

        // Load hit against a pending store
        push(SEL_WORD, 32'h40, 32'hDEAD_BEEF);
        ld_addr = 32'h43;
        settle();
        check("hit_43", ld_hit, 1'b1);
        ld_addr = 32'h44;
        settle();
        check("hit_44", ld_hit, 1'b0);
        ld_addr = 32'h3F;
        settle();
        check("hit_3f", ld_hit, 1'b0);
        ld_addr = 32'h43;
        mem_ack = 1'b1;
        settle();
        check("hit_during_pop", ld_hit, 1'b1);
        tick();
        mem_ack = 1'b0;
        check("hit_after_pop", ld_hit, 1'b0);
        check("hit_after_pop_empty", empty, 1'b1);

        // Fill to full across the pointer wrap (three pushes so far)
        for (int i = 0; i < DEPTH; i++) begin
            drive(SEL_WORD, (i + 1) << 8, 32'hC0DE_0000 + i);
            settle();
            check("fill_ready", st_ready, 1'b1);
            tick();
        end
        idle();
        check("full_count", count, DEPTH);
        check("full_ready", st_ready, 1'b0);

        // Fifth store is refused while full
        drive(SEL_WORD, 32'h500, 32'hC0DE_0004);
        settle();
        check("fifth_ready", st_ready, 1'b0);
        tick();
        check("fifth_count", count, DEPTH);
        check_head("fifth_head", 32'h100, 4'b1111, 32'hC0DE_0000);

        // Ack while full: pop happens, the held push is still refused
        mem_ack = 1'b1;
        settle();
        check("ackfull_ready", st_ready, 1'b0);
        check("ackfull_count_now", count, DEPTH);
        tick();
        mem_ack = 1'b0;
        check("ackfull_count_next", count, DEPTH - 1);
        check_head("ackfull_head", 32'h200, 4'b1111, 32'hC0DE_0001);

        // Push and pop in the same cycle keep count unchanged
        mem_ack = 1'b1;
        settle();
        check("pushpop_ready", st_ready, 1'b1);
        tick();
        idle();
        mem_ack = 1'b0;
        check("pushpop_count", count, DEPTH - 1);

        // Back-to-back drain in issue order
        mem_ack = 1'b1;
        check_head("drain0", 32'h300, 4'b1111, 32'hC0DE_0002);
        tick();
        check_head("drain1", 32'h400, 4'b1111, 32'hC0DE_0003);
        tick();
        check_head("drain2", 32'h500, 4'b1111, 32'hC0DE_0004);
        tick();
        mem_ack = 1'b0;
        check_idle_outputs("drain_done");

        // Tail merge (or separate pushes when merging is compiled out)
        push(SEL_WORD, 32'h100, 32'h0000_0100);
        push(SEL_BYTE, 32'h205, 32'h11);
        push(SEL_BYTE, 32'h206, 32'h22);
`ifdef STORE_MERGE_EN
        check("merge_count", count, 2);
`else
        check("merge_count", count, 3);
`endif
        check_head("merge_head", 32'h100, 4'b1111, 32'h0000_0100);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
`ifdef STORE_MERGE_EN
        check_head("merge_tail", 32'h204, 4'b0110, 32'h0022_1100);
`else
        check_head("merge_tail", 32'h204, 4'b0010, 32'h0000_1100);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_head("merge_third", 32'h204, 4'b0100, 32'h0022_0000);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("merge_reset");

        // Reset during a handshake discards everything
        push(SEL_WORD, 32'h600, 32'h6);
        push(SEL_WORD, 32'h700, 32'h7);
        push(SEL_WORD, 32'h800, 32'h8);
        check("midrst_count_before", count, 3);
        mem_ack = 1'b1;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b0;
        check_idle_outputs("midrst");
        ld_addr = 32'h700;
        settle();
        check("midrst_ld_hit", ld_hit, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
